// File: rtl/pixel_seq_pkg.sv
// Shared types and default widths for the pixel frame sequencer.
// The optional inter-line blanking gap is enabled with SEQ_LINE_GAP_EN.
package pixel_seq_pkg;

    localparam int DATA_W = 64;
    localparam int COLS_W = 12;
    localparam int ROWS_W = 12;
    localparam int GAP_W  = 8;
    localparam int FCNT_W = 16;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        STREAM = 2'd1,
        GAP    = 2'd2
    } seq_state_e;

    typedef struct packed {
        logic sof;
        logic eol;
        logic eof;
    } seq_flags_t;

endpackage

// File: rtl/pixel_reg_slice.sv
// Single-entry valid/ready output register carrying a beat and its frame flags.
// Accepts a new beat whenever it is empty or being drained in the same cycle.
module pixel_reg_slice #(
    parameter int DATA_W = pixel_seq_pkg::DATA_W
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [DATA_W-1:0]         in_data_i,
    input  pixel_seq_pkg::seq_flags_t in_flags_i,
    input  logic                      in_valid_i,
    output logic                      in_ready_o,
    output logic [DATA_W-1:0]         out_data_o,
    output pixel_seq_pkg::seq_flags_t out_flags_o,
    output logic                      out_valid_o,
    input  logic                      out_ready_i
);
    import pixel_seq_pkg::*;

    logic [DATA_W-1:0] data_q, data_d;
    seq_flags_t        flags_q, flags_d;
    logic              valid_q, valid_d;

    assign in_ready_o = !valid_q || out_ready_i;

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        data_d  = data_q;
        flags_d = flags_q;
        valid_d = valid_q;
        if (in_ready_o) begin
            valid_d = in_valid_i;
            if (in_valid_i) begin
                data_d  = in_data_i;
                flags_d = in_flags_i;
            end
        end
    end

    // NOTE: the data register is reset too, because the sink must see m_data=0 out of reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: sequential state uses non-blocking assignments so all registers update together.
            data_q  <= '0;
            flags_q <= '0;
            valid_q <= 1'b0;
        end else begin
            data_q  <= data_d;
            flags_q <= flags_d;
            valid_q <= valid_d;
        end
    end

    assign out_data_o  = data_q;
    assign out_flags_o = flags_q;
    assign out_valid_o = valid_q;

endmodule

// File: rtl/pixel_frame_sequencer.sv
// Gates a pixel beat stream into frames of cfg_rows x cfg_cols and tags SOF/EOL/EOF.
// Define SEQ_LINE_GAP_EN to add the cfg_gap port and inter-line blanking state.
module pixel_frame_sequencer #(
    parameter int DATA_W = pixel_seq_pkg::DATA_W,
    parameter int COLS_W = pixel_seq_pkg::COLS_W,
    parameter int ROWS_W = pixel_seq_pkg::ROWS_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [COLS_W-1:0] cfg_cols,
    input  logic [ROWS_W-1:0] cfg_rows,
    input  logic              cfg_continuous,
`ifdef SEQ_LINE_GAP_EN
    input  logic [7:0]        cfg_gap,
`endif
    input  logic              start,
    input  logic              stop,
    input  logic [DATA_W-1:0] s_data,
    input  logic              s_valid,
    output logic              s_ready,
    output logic [DATA_W-1:0] m_data,
    output logic              m_valid,
    input  logic              m_ready,
    output logic              m_sof,
    output logic              m_eol,
    output logic              m_eof,
    output logic              busy,
    output logic [15:0]       frame_cnt,
    output logic              err_cfg
);
    import pixel_seq_pkg::*;

    seq_state_e        state_q, state_d;
    logic [COLS_W-1:0] col_q, col_d, cols_q, cols_d;
    logic [ROWS_W-1:0] row_q, row_d, rows_q, rows_d;
    logic              cont_q, cont_d;
    logic              stop_pend_q, stop_pend_d;
    logic [15:0]       frame_cnt_q, frame_cnt_d;
    logic              err_q, err_d;
`ifdef SEQ_LINE_GAP_EN
    logic [7:0]        gap_q, gap_d;
    logic [7:0]        gap_cnt_q, gap_cnt_d;
`endif

    logic       slice_in_ready;
    logic       accept;
    seq_flags_t beat_flags;
    seq_flags_t out_flags;

    assign s_ready = (state_q == STREAM) && slice_in_ready;
    assign accept  = s_valid && s_ready;

    always_comb begin
        beat_flags.sof = (col_q == '0) && (row_q == '0);
        beat_flags.eol = (col_q == cols_q - COLS_W'(1));
        beat_flags.eof = beat_flags.eol && (row_q == rows_q - ROWS_W'(1));
    end

    always_comb begin
        state_d     = state_q;
        col_d       = col_q;
        row_d       = row_q;
        cols_d      = cols_q;
        rows_d      = rows_q;
        cont_d      = cont_q;
        stop_pend_d = stop_pend_q;
        frame_cnt_d = frame_cnt_q;
        err_d       = 1'b0;
`ifdef SEQ_LINE_GAP_EN
        gap_d       = gap_q;
        gap_cnt_d   = gap_cnt_q;
`endif
        case (state_q)
            IDLE: begin
                if (start) begin
                    if ((cfg_cols != '0) && (cfg_rows != '0)) begin
                        cols_d      = cfg_cols;
                        rows_d      = cfg_rows;
                        cont_d      = cfg_continuous;
                        col_d       = '0;
                        row_d       = '0;
                        // A stop arriving with start limits the run to one frame.
                        stop_pend_d = stop;
`ifdef SEQ_LINE_GAP_EN
                        gap_d       = cfg_gap;
`endif
                        state_d     = STREAM;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            STREAM: begin
                if (stop) stop_pend_d = 1'b1;
                if (accept) begin
                    if (beat_flags.eol) begin
                        col_d = '0;
                        if (beat_flags.eof) begin
                            row_d       = '0;
                            frame_cnt_d = frame_cnt_q + 16'd1;
                            if (!cont_q || stop_pend_q || stop) begin
                                state_d     = IDLE;
                                stop_pend_d = 1'b0;
                            end
                        end else begin
                            row_d = row_q + ROWS_W'(1);
`ifdef SEQ_LINE_GAP_EN
                            if (gap_q != 8'd0) begin
                                state_d   = GAP;
                                gap_cnt_d = gap_q;
                            end
`endif
                        end
                    end else begin
                        col_d = col_q + COLS_W'(1);
                    end
                end
            end
`ifdef SEQ_LINE_GAP_EN
            GAP: begin
                if (stop) stop_pend_d = 1'b1;
                if (gap_cnt_q <= 8'd1) begin
                    state_d = STREAM;
                end else begin
                    gap_cnt_d = gap_cnt_q - 8'd1;
                end
            end
`endif
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            col_q       <= '0;
            row_q       <= '0;
            cols_q      <= '0;
            rows_q      <= '0;
            cont_q      <= 1'b0;
            stop_pend_q <= 1'b0;
            frame_cnt_q <= '0;
            err_q       <= 1'b0;
`ifdef SEQ_LINE_GAP_EN
            gap_q       <= '0;
            gap_cnt_q   <= '0;
`endif
        end else begin
            state_q     <= state_d;
            col_q       <= col_d;
            row_q       <= row_d;
            cols_q      <= cols_d;
            rows_q      <= rows_d;
            cont_q      <= cont_d;
            stop_pend_q <= stop_pend_d;
            frame_cnt_q <= frame_cnt_d;
            err_q       <= err_d;
`ifdef SEQ_LINE_GAP_EN
            gap_q       <= gap_d;
            gap_cnt_q   <= gap_cnt_d;
`endif
        end
    end

    pixel_reg_slice #(
        .DATA_W (DATA_W)
    ) u_out_slice (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_data_i   (s_data),
        .in_flags_i  (beat_flags),
        .in_valid_i  (accept),
        .in_ready_o  (slice_in_ready),
        .out_data_o  (m_data),
        .out_flags_o (out_flags),
        .out_valid_o (m_valid),
        .out_ready_i (m_ready)
    );

    assign m_sof     = out_flags.sof;
    assign m_eol     = out_flags.eol;
    assign m_eof     = out_flags.eof;
    assign busy      = (state_q != IDLE) || m_valid;
    assign frame_cnt = frame_cnt_q;
    assign err_cfg   = err_q;

endmodule

// File: tb/tb_pixel_frame_sequencer.sv
// Self-checking bench for pixel_frame_sequencer: a positional frame model predicts
// every output beat; directed scenarios pin timing with literal expectations.
module tb_pixel_frame_sequencer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [11:0] cfg_cols;
    logic [11:0] cfg_rows;
    logic        cfg_continuous;
`ifdef SEQ_LINE_GAP_EN
    logic [7:0]  cfg_gap;
`endif
    logic        start, stop;
    logic [63:0] s_data;
    logic        s_valid, s_ready;
    logic [63:0] m_data;
    logic        m_valid, m_ready;
    logic        m_sof, m_eol, m_eof;
    logic        busy;
    logic [15:0] frame_cnt;
    logic        err_cfg;

    always #5 clk = ~clk;

    pixel_frame_sequencer dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .cfg_cols       (cfg_cols),
        .cfg_rows       (cfg_rows),
        .cfg_continuous (cfg_continuous),
`ifdef SEQ_LINE_GAP_EN
        .cfg_gap        (cfg_gap),
`endif
        .start          (start),
        .stop           (stop),
        .s_data         (s_data),
        .s_valid        (s_valid),
        .s_ready        (s_ready),
        .m_data         (m_data),
        .m_valid        (m_valid),
        .m_ready        (m_ready),
        .m_sof          (m_sof),
        .m_eol          (m_eol),
        .m_eof          (m_eof),
        .busy           (busy),
        .frame_cnt      (frame_cnt),
        .err_cfg        (err_cfg)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Two packed 0RGB pixels derived from the source sequence number.
    function automatic logic [63:0] make_data(input int k);
        logic [23:0] a, b;
        a = 24'(k * 3 + 1);
        b = 24'(k) ^ 24'h5A5A5A;
        return {8'h00, a, 8'h00, b};
    endfunction

    // Model state: the k-th beat of a run sits at column k%cols, line (k/cols)%rows.
    int out_total = 0, in_total = 0, cyc = 0;
    int out_base = 0, in_base = 0, exp_base = 0;
    int exp_cols = 1, exp_rows = 1;
    int hs_cyc[16];
    int in_cyc[16];
    logic [2:0] flag_log[16];
    int busy_fall_cyc = 0, last_hs_cyc = 0;
    int rdy_mode = 0;
    int src_k = 0;

    initial begin : compare_proc
        logic        prev_stall, prev_busy;
        logic [63:0] prev_data;
        logic [2:0]  prev_flags, e_flags;
        int k, col, row;
        prev_stall = 1'b0;
        prev_busy  = 1'b0;
        prev_data  = '0;
        prev_flags = '0;
        forever begin
            @(negedge clk);
            cyc++;
            if (rst_n) begin
                if (prev_stall) begin
                    check("hold_valid", 64'(m_valid), 64'd1);
                    check("hold_data", m_data, prev_data);
                    check("hold_flags", 64'({m_sof, m_eol, m_eof}), 64'(prev_flags));
                end
                if (m_valid && m_ready) begin
                    k   = out_total - out_base;
                    col = k % exp_cols;
                    row = (k / exp_cols) % exp_rows;
                    e_flags[2] = (col == 0) && (row == 0);
                    e_flags[1] = (col == exp_cols - 1);
                    e_flags[0] = (col == exp_cols - 1) && (row == exp_rows - 1);
                    check("beat_data", m_data, make_data(exp_base + k));
                    check("beat_flags", 64'({m_sof, m_eol, m_eof}), 64'(e_flags));
                    if (k < 16) begin
                        flag_log[k] = {m_sof, m_eol, m_eof};
                        hs_cyc[k]   = cyc;
                    end
                    last_hs_cyc = cyc;
                    out_total++;
                end
                if (s_valid && s_ready) begin
                    k = in_total - in_base;
                    if (k < 16) in_cyc[k] = cyc;
                    in_total++;
                end
                prev_stall = m_valid && !m_ready;
                prev_data  = m_data;
                prev_flags = {m_sof, m_eol, m_eof};
                if (prev_busy && !busy) busy_fall_cyc = cyc;
                prev_busy = busy;
            end else begin
                prev_stall = 1'b0;
                prev_busy  = 1'b0;
            end
        end
    end

    // Source and sink driver: next beat after each handshake; m_ready always-on or toggling.
    initial begin : driver_proc
        logic fire;
        s_data  = make_data(0);
        m_ready = 1'b1;
        forever begin
            @(negedge clk);
            fire = s_valid && s_ready;
            @(posedge clk);
            #1;
            if (fire) src_k++;
            s_data  = make_data(src_k);
            m_ready = (rdy_mode == 1) ? ~m_ready : 1'b1;
        end
    end

    initial begin : watchdog
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic rebase(input int cols, input int rows);
        exp_cols = cols;
        exp_rows = rows;
        out_base = out_total;
        in_base  = in_total;
        exp_base = src_k;
    endtask

    task automatic do_start();
        @(posedge clk);
        #1 start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (busy && n < 400);
        check(name, 64'(busy), 64'd0);
    endtask

    task automatic wait_beats(input int cnt);
        int n;
        n = 0;
        while ((out_total - out_base) < cnt && n < 400) begin
            @(negedge clk);
            n++;
        end
        check("wait_beats_timeout", 64'((out_total - out_base) >= cnt), 64'd1);
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_s_ready"}, 64'(s_ready), 64'd0);
        check({tag, "_m_valid"}, 64'(m_valid), 64'd0);
        check({tag, "_m_data"}, m_data, 64'd0);
        check({tag, "_flags"}, 64'({m_sof, m_eol, m_eof}), 64'd0);
        check({tag, "_busy"}, 64'(busy), 64'd0);
        check({tag, "_frame_cnt"}, 64'(frame_cnt), 64'd0);
        check({tag, "_err_cfg"}, 64'(err_cfg), 64'd0);
    endtask

    initial begin : main
        int gap_exp;
        rst_n          = 1'b0;
        start          = 1'b0;
        stop           = 1'b0;
        s_valid        = 1'b0;
        cfg_cols       = 12'd4;
        cfg_rows       = 12'd2;
        cfg_continuous = 1'b0;
`ifdef SEQ_LINE_GAP_EN
        cfg_gap        = 8'd0;
`endif
        #23;
        check_reset_values("reset");
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Single-shot 4x2 frame with an always-ready sink.
        s_valid = 1'b1;
        rebase(4, 2);
        @(posedge clk);
        #1 start = 1'b1;
        check("idle_s_ready", 64'(s_ready), 64'd0);
        @(posedge clk);
        #1 start = 1'b0;
        @(negedge clk);
        check("start_to_ready", 64'(s_ready), 64'd1);
        wait_idle("t1_idle");
        check("t1_count", 64'(out_total - out_base), 64'd8);
        check("t1_frame_cnt", 64'(frame_cnt), 64'd1);
        check("t1_sof_beat0", 64'(flag_log[0]), 64'b100);
        check("t1_beat1", 64'(flag_log[1]), 64'b000);
        check("t1_eol_beat3", 64'(flag_log[3]), 64'b010);
        check("t1_beat4", 64'(flag_log[4]), 64'b000);
        check("t1_eof_beat7", 64'(flag_log[7]), 64'b011);
        check("t1_throughput", 64'(hs_cyc[7] - hs_cyc[0]), 64'd7);
        check("t1_busy_fall", 64'(busy_fall_cyc), 64'(last_hs_cyc + 1));

        // Same frame with a toggling sink.
        rdy_mode = 1;
        rebase(4, 2);
        do_start();
        wait_idle("t2_idle");
        rdy_mode = 0;
        check("t2_count", 64'(out_total - out_base), 64'd8);
        check("t2_frame_cnt", 64'(frame_cnt), 64'd2);
        check("t2_eof_beat7", 64'(flag_log[7]), 64'b011);

        // Continuous 2x2, stop during the second frame.
        cfg_cols       = 12'd2;
        cfg_rows       = 12'd2;
        cfg_continuous = 1'b1;
        rebase(2, 2);
        do_start();
        wait_beats(4);
        @(posedge clk);
        #1 stop = 1'b1;
        @(posedge clk);
        #1 stop = 1'b0;
        wait_idle("t3_idle");
        repeat (5) @(negedge clk);
        cfg_continuous = 1'b0;
        check("t3_count", 64'(out_total - out_base), 64'd8);
        check("t3_frame_cnt", 64'(frame_cnt), 64'd4);
        check("t3_eof_f1", 64'(flag_log[3]), 64'b011);
        check("t3_sof_f2", 64'(flag_log[4]), 64'b100);
        check("t3_no_bubble", 64'(hs_cyc[4] - hs_cyc[3]), 64'd1);
        check("t3_eof_f2", 64'(flag_log[7]), 64'b011);
        check("t3_idle_s_ready", 64'(s_ready), 64'd0);

        // Zero configuration is rejected with a one-cycle error pulse.
        cfg_cols = 12'd0;
        cfg_rows = 12'd2;
        rebase(1, 1);
        do_start();
        @(negedge clk);
        check("t4_err_pulse", 64'(err_cfg), 64'd1);
        check("t4_s_ready", 64'(s_ready), 64'd0);
        @(negedge clk);
        check("t4_err_clear", 64'(err_cfg), 64'd0);
        check("t4_busy", 64'(busy), 64'd0);
        cfg_cols = 12'd4;
        cfg_rows = 12'd0;
        do_start();
        @(negedge clk);
        check("t4_err_rows", 64'(err_cfg), 64'd1);
        repeat (3) @(negedge clk);
        check("t4_no_beats", 64'(out_total - out_base), 64'd0);
        check("t4_frame_cnt", 64'(frame_cnt), 64'd4);

        // 3x3 frame: two-cycle blanking after lines 0 and 1 when the gap is built in.
        cfg_cols = 12'd3;
        cfg_rows = 12'd3;
`ifdef SEQ_LINE_GAP_EN
        cfg_gap = 8'd2;
        gap_exp = 3;
`else
        gap_exp = 1;
`endif
        rebase(3, 3);
        do_start();
        wait_idle("t5_idle");
        check("t5_count", 64'(out_total - out_base), 64'd9);
        check("t5_frame_cnt", 64'(frame_cnt), 64'd5);
        check("t5_in_back2back", 64'(in_cyc[1] - in_cyc[0]), 64'd1);
        check("t5_gap_line0", 64'(in_cyc[3] - in_cyc[2]), 64'(gap_exp));
        check("t5_gap_line1", 64'(in_cyc[6] - in_cyc[5]), 64'(gap_exp));
        check("t5_last_line", 64'(in_cyc[8] - in_cyc[6]), 64'd2);
        check("t5_eol_beat2", 64'(flag_log[2]), 64'b010);
        check("t5_eof_beat8", 64'(flag_log[8]), 64'b011);
`ifdef SEQ_LINE_GAP_EN
        cfg_gap = 8'd0;
`endif

        // Reset in the middle of a frame, then a fresh frame.
        cfg_cols = 12'd4;
        cfg_rows = 12'd2;
        rebase(4, 2);
        do_start();
        wait_beats(5);
        #1 rst_n = 1'b0;
        #1;
        check_reset_values("midreset");
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        rebase(4, 2);
        do_start();
        wait_idle("t6_idle");
        check("t6_count", 64'(out_total - out_base), 64'd8);
        check("t6_sof", 64'(flag_log[0]), 64'b100);
        check("t6_eof", 64'(flag_log[7]), 64'b011);
        check("t6_frame_cnt", 64'(frame_cnt), 64'd1);

        s_valid = 1'b0;
        repeat (2) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/pixel_frame_sequencer.md
# pixel_frame_sequencer

Frame-level controller placed between the pixel source (64-bit beats carrying two packed 0RGB pixels, valid/ready) and the downstream video sink. It gates the source stream into frames of cfg_rows lines × cfg_cols beats, tags each beat with SOF/EOL/EOF flags, and supports single-shot or continuous operation with frame-boundary stop. An optional inter-line blanking gap holds off the source between lines.

## Interface
- DATA_W, 64, beat width
- COLS_W, 12, width of beats-per-line count
- ROWS_W, 12, width of lines-per-frame count

- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- cfg_cols  in  COLS_W  beats per line; latched on accepted start
- cfg_rows  in  ROWS_W  lines per frame; latched on accepted start
- cfg_continuous  in  1  1 = auto-restart after each frame; latched on accepted start
- cfg_gap  in  8  blanking cycles between lines (present only with SEQ_LINE_GAP_EN)
- start  in  1  single-cycle start request
- stop  in  1  single-cycle stop request, honoured at frame end
- s_data  in  DATA_W  source beat
- s_valid  in  1  source valid
- s_ready  out  1  sequencer accepts beat
- m_data  out  DATA_W  registered output beat
- m_valid  out  1  output valid
- m_ready  in  1  sink ready
- m_sof  out  1  first beat of frame
- m_eol  out  1  last beat of line
- m_eof  out  1  last beat of frame
- busy  out  1  state != IDLE or m_valid
- frame_cnt  out  16  completed frames, wraps 0xFFFF→0
- err_cfg  out  1  one-cycle pulse: start rejected for zero config

## Operation
- States: IDLE, STREAM, GAP (GAP only with macro).
- IDLE: start with cfg_cols≠0 and cfg_rows≠0 → latch config, clear col/row, → STREAM. Zero in either field → stay IDLE, err_cfg=1 next cycle. stop in IDLE ignored.
- STREAM: s_ready = !m_valid || m_ready. Accept = s_valid && s_ready; on accept load m_data, set m_valid, col++.
- Flags on loaded beat: sof = col==0 && row==0; eol = col==cols-1; eof = eol && row==rows-1.
- Line end (eol accept): col←0, row++; with macro and cfg_gap≠0 and not eof → GAP.
- Frame end (eof accept): row←0, frame_cnt++. If cfg_continuous && !stop_pending → STREAM (next frame). Else → IDLE, stop_pending cleared.
- GAP: s_ready=0, down-counter from latched cfg_gap; at 1 → STREAM. Output register still drains.
- stop while STREAM/GAP sets stop_pending; start outside IDLE ignored. start and stop same cycle in IDLE: frame starts, stop_pending set (single frame).
- m_valid held until m_ready; m_data/flags stable while m_valid && !m_ready.
- Reset mid-frame: immediate return to IDLE, in-flight beat discarded.

## Timing
- Reset values: s_ready=0, m_valid=0, m_data=0, m_sof/m_eol/m_eof=0, busy=0, frame_cnt=0, err_cfg=0.
- start accepted cycle N → STREAM, s_ready may assert cycle N+1.
- Input accept at N → m_valid/m_data at N+1 (latency 1). Full throughput: 1 beat/cycle with m_ready=1.
- Continuous: no bubble between frames; eof beat followed by sof beat on consecutive cycles.
- Gap: eol accepted cycle N → s_ready=0 for cycles N+1..N+cfg_gap.
- busy falls the cycle after last beat leaves the output register.

## Configuration
- SEQ_LINE_GAP_EN defined: cfg_gap port and GAP state present, blanking as above.
- Undefined: no cfg_gap port, no GAP state; lines back-to-back, identical otherwise.

## Structure
- Package pixel_seq_pkg: state enum (IDLE, STREAM, GAP), flag struct {sof, eol, eof}, default widths DATA_W/COLS_W/ROWS_W.
- Sub-module pixel_reg_slice: single-entry valid/ready register carrying data+flags; sequencer holds FSM, counters, ready gating.

## Test plan
- cols=4, rows=2, single-shot, s_valid/m_ready=1 → 8 beats, sof on beat 0, eol on 3 and 7, eof on 7, frame_cnt=1, busy low 1 cycle after.
- Same config, m_ready toggling 1010… → no beat lost/duplicated, data stable while stalled, 8 beats in order.
- cols=2, rows=2, continuous, stop pulsed mid-frame 2 → exactly 2 frames, frame_cnt=2, IDLE after second eof.
- start with cfg_cols=0 → err_cfg pulse, state stays IDLE, s_ready=0.
- SEQ_LINE_GAP_EN, cols=3, rows=3, cfg_gap=2 → s_ready low exactly 2 cycles after lines 0 and 1, none after last line.
- rst_n asserted on beat 5 of 8 → all outputs to reset values immediately; fresh start yields correct sof on first beat.
